xcorr_lag_engine: RTL and testbench
===================================

// Module: xcorr_lag_engine
// PURPOSE
// - Parametrised successor of the mic-pair cross-correlator. Captures one N-sample frame of two
//   signed sample streams, then computes r[k] = sum_n x[n]*y[n+k] for k = -MAX_LAG..+MAX_LAG.
//   Terms with n+k outside 0..N-1 contribute zero.
// - Streams every r[k] and reports the peak lag as lag_diff.
// - Sits in the mic subsystem between the sign-extension stages and the DOA/lag consumer.
// PARAMETERS
// - W        16   sample width, two's complement
// - N        512  frame length in samples (>=4)
// - MAX_LAG  31   largest |lag| evaluated; 2*MAX_LAG+1 lags per frame
// - ACC_W    48   accumulator/result width; elaboration error if ACC_W < 2*W+clog2(N)
// - LAG_W    6    signed lag width; elaboration error if MAX_LAG > 2^(LAG_W-1)-1
// PORTS
// - clk           in   1      single clock (60 MHz domain)
// - rst_n         in   1      asynchronous active-low reset
// - start         in   1      1-cycle pulse: begin new frame capture (aborts any frame in progress)
// - in_valid      in   1      series_x/series_y sample strobe
// - series_x      in   W      signed sample, channel x
// - series_y      in   W      signed sample, channel y
// - busy          out  1      high in LOAD or CALC
// - complete      out  1      1-cycle pulse, result/result_lag valid
// - result        out  ACC_W  signed r[k]
// - result_lag    out  LAG_W  signed k belonging to result
// - done          out  1      1-cycle pulse after last lag of a frame
// - lag_diff      out  LAG_W  signed lag of peak r[k]; updated only at done, held otherwise
// - peak_value    out  ACC_W  signed r[lag_diff]; updated with lag_diff
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; write pointer, lag counter and accumulator cleared.
// - FSM states:
//   - IDLE: on start -> LOAD.
//   - LOAD: on each in_valid, write sample pair at wr_ptr and increment wr_ptr. Exit when
//     wr_ptr reaches N: go to CALC with k = -MAX_LAG.
//   - CALC: per lag, sweep n = 0..N-1, one n per cycle.
//     - 1-cycle RAM read, 1 registered multiply, accumulate: N+2 cycles per lag.
//     - At end of lag: pulse complete with result = r[k] and result_lag = k; k++.
//     - After k = +MAX_LAG: go to DONE.
//   - DONE: pulse done for 1 cycle, load lag_diff/peak_value from the running peak -> IDLE.
// - Latency: from last captured sample to done = (2*MAX_LAG+1)*(N+2)+1 cycles.
//   Defaults: 63*514+1 = 32383.
// - Arithmetic: full-precision signed W x W product, sign-extended into ACC_W. No saturation
//   (width check guarantees no overflow).
// - Peak: strict signed greater-than compare against the running max; max is initialised from
//   r[-MAX_LAG]. Ties keep the earlier (more negative) lag. Compares signed value, not magnitude.
// - Sign convention: y[n] = x[n-d] gives lag_diff = +d.
// - start in LOAD/CALC/DONE: abort and restart LOAD with wr_ptr = 0. No done for the aborted
//   frame; lag_diff/peak_value keep previous values.
// - start with in_valid in the same cycle: that sample is dropped; capture starts next cycle.
// - in_valid outside LOAD is ignored. in_valid gaps in LOAD simply stall capture (no timeout).
// - busy drops in the cycle done is asserted.
// STRUCTURE
// - Shared header package xcorr_pkg.vh: FSM state encodings (IDLE/LOAD/CALC/DONE), CALC pipeline
//   depth constant (2), width-check macros.
// - Sub-module xcorr_frame_ram: simple dual-port synchronous RAM (1 write, 1 read port),
//   depth N, width W. Instantiated twice (x, y).
// - Top-level: FSM, pointer/lag counters, y-address range check, product register,
//   accumulator, peak tracker.
// TESTING (bench overrides N=64, MAX_LAG=7 except T4)
// - T1 reset: assert rst_n low mid-CALC -> all outputs 0 immediately; busy=0; no complete/done
//   after release until a new start.
// - T2 delay: x[10]=1000, y[13]=1000, rest 0 -> 15 complete pulses, result_lag -7..+7 ascending;
//   r[3]=1000000 (all others 0); done 15*66+1 cycles after the last sample; lag_diff=+3,
//   peak_value=1000000.
// - T3 ties/negative: all-zero frame -> lag_diff=-7, peak_value=0.
//   x[5]=100, y[5]=-100 only -> r[0]=-10000, others 0, lag_diff=-7 (signed max, not |r|).
// - T4 full scale (defaults): x=y=-32768 for all 512 samples -> result at k=0 is 2^39,
//   at k=+31 is 481*2^30; no overflow; lag_diff=0.
// - T5 abort: start pulse mid-CALC of frame A, then frame B with delay -5 -> no done for A;
//   lag_diff keeps old value until B's done, then -5.
// - T6 handshake: random in_valid gaps during LOAD, plus start with in_valid in the same cycle
//   -> that sample dropped; result identical to gap-free capture of the remaining 64 samples.

Source files
------------

// File: rtl/xcorr_lag_engine_pkg.sv
// Shared types and constants for the cross-correlation lag engine.
package xcorr_lag_engine_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCalc = 2'd2,
        StDone = 2'd3
    } state_t;

    // RAM read stage plus product register between address issue and accumulate.
    localparam int unsigned CALC_PIPE_DEPTH = 2;

    function automatic int unsigned acc_w_min(input int unsigned w, input int unsigned n);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/xcorr_lag_engine_if.sv
// Sample stream in, correlation results out, between the mic front end and the lag engine.
interface xcorr_lag_engine_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned ACC_W = 48,
    parameter int unsigned LAG_W = 6
);
    logic                    start;
    logic                    in_valid;
    logic signed [W-1:0]     series_x;
    logic signed [W-1:0]     series_y;
    logic                    busy;
    logic                    complete;
    logic signed [ACC_W-1:0] result;
    logic signed [LAG_W-1:0] result_lag;
    logic                    done;
    logic signed [LAG_W-1:0] lag_diff;
    logic signed [ACC_W-1:0] peak_value;

    modport master (
        output start, in_valid, series_x, series_y,
        input  busy, complete, result, result_lag, done, lag_diff, peak_value
    );

    modport slave (
        input  start, in_valid, series_x, series_y,
        output busy, complete, result, result_lag, done, lag_diff, peak_value
    );
endinterface

// File: rtl/xcorr_lag_engine_frame_ram.sv
// Simple dual-port frame buffer: one synchronous write port, one registered read port.
module xcorr_lag_engine_frame_ram #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = 9
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/xcorr_lag_engine.sv
// Captures one N-sample frame of two channels, streams r[k] = sum x[n]*y[n+k] for every lag
// in -MAX_LAG..+MAX_LAG and reports the lag of the largest r[k].
module xcorr_lag_engine
    import xcorr_lag_engine_pkg::*;
#(
    parameter int unsigned W       = 16,
    parameter int unsigned N       = 512,
    parameter int unsigned MAX_LAG = 31,
    parameter int unsigned ACC_W   = 48,
    parameter int unsigned LAG_W   = 6
) (
    input logic               clk,
    input logic               rst_n,
    xcorr_lag_engine_if.slave bus
);
    localparam int unsigned AW  = $clog2(N);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned CW  = $clog2(N + CALC_PIPE_DEPTH);
    localparam int unsigned EXT = ACC_W - 2 * W;
    localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(N + CALC_PIPE_DEPTH - 1);
    localparam logic signed [LAG_W-1:0] LAG_MIN = LAG_W'(0 - int'(MAX_LAG));
    localparam logic signed [LAG_W-1:0] LAG_MAX = LAG_W'(MAX_LAG);

    if (ACC_W < acc_w_min(W, N)) begin : g_chk_acc
        $error("xcorr_lag_engine: ACC_W too small for W and N");
    end
    if (MAX_LAG > (2 ** (LAG_W - 1)) - 1) begin : g_chk_lag
        $error("xcorr_lag_engine: LAG_W too small for MAX_LAG");
    end
    if (N < 4) begin : g_chk_n
        $error("xcorr_lag_engine: N must be at least 4");
    end

    state_t                  r_state, w_state_nxt;
    logic [PW-1:0]           r_wr_ptr;
    logic [CW-1:0]           r_cyc;
    logic signed [LAG_W-1:0] r_lag;
    logic                    r_rd_ok;
    logic signed [ACC_W-1:0] r_prod, r_acc, r_result, r_peak_run, r_peak_out;
    logic signed [LAG_W-1:0] r_result_lag, r_peak_lag, r_lag_diff;
    logic                    r_complete;

    logic                    w_we, w_load_end, w_lag_end, w_issue, w_busy, w_done;
    int                      w_y_idx;
    logic signed [W-1:0]     w_x_rd, w_y_rd;
    logic signed [2*W-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_final;

    assign w_we       = (r_state == StLoad) && bus.in_valid && !bus.start;
    assign w_load_end = w_we && (r_wr_ptr == PTR_LAST);
    assign w_lag_end  = (r_cyc == CYC_LAST);
    assign w_y_idx    = int'(r_cyc) + int'(r_lag);
    // Reads whose y index falls outside the frame become zero terms.
    assign w_issue    = (int'(r_cyc) < int'(N)) && (w_y_idx >= 0) && (w_y_idx < int'(N));
    assign w_prod     = w_x_rd * w_y_rd;
    assign w_final    = r_acc + r_prod;

    xcorr_lag_engine_frame_ram #(.W(W), .DEPTH(N), .AW(AW)) u_ram_x (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (bus.series_x),
        .i_raddr (r_cyc[AW-1:0]),
        .o_rdata (w_x_rd)
    );

    xcorr_lag_engine_frame_ram #(.W(W), .DEPTH(N), .AW(AW)) u_ram_y (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (bus.series_y),
        .i_raddr (w_y_idx[AW-1:0]),
        .o_rdata (w_y_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) w_state_nxt = StLoad;
            end
            StLoad: begin
                w_busy = 1'b1;
                if (!bus.start && w_load_end) w_state_nxt = StCalc;
            end
            StCalc: begin
                w_busy = 1'b1;
                if (bus.start) begin
                    w_state_nxt = StLoad;
                end else if (w_lag_end && (r_lag == LAG_MAX)) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (bus.start) begin
                    w_state_nxt = StLoad;
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_cyc        <= '0;
            r_lag        <= '0;
            r_rd_ok      <= 1'b0;
            r_prod       <= '0;
            r_acc        <= '0;
            r_result     <= '0;
            r_result_lag <= '0;
            r_complete   <= 1'b0;
            r_peak_run   <= '0;
            r_peak_lag   <= '0;
            r_peak_out   <= '0;
            r_lag_diff   <= '0;
        end else begin
            r_complete <= 1'b0;
            r_rd_ok    <= (r_state == StCalc) && w_issue && !bus.start;
            r_prod     <= r_rd_ok ? {{EXT{w_prod[2*W-1]}}, w_prod} : '0;

            if (bus.start) begin
                r_wr_ptr <= '0;
            end else if (w_we) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end

            if ((r_state == StCalc) && !bus.start) begin
                if (w_lag_end) begin
                    r_cyc        <= '0;
                    r_acc        <= '0;
                    r_lag        <= r_lag + LAG_W'(1);
                    r_complete   <= 1'b1;
                    r_result     <= w_final;
                    r_result_lag <= r_lag;
                    // Strict compare: ties keep the earlier, more negative lag.
                    if ((r_lag == LAG_MIN) || (w_final > r_peak_run)) begin
                        r_peak_run <= w_final;
                        r_peak_lag <= r_lag;
                    end
                end else begin
                    r_cyc <= r_cyc + CW'(1);
                    r_acc <= w_final;
                end
            end else begin
                r_cyc <= '0;
                r_acc <= '0;
                r_lag <= LAG_MIN;
            end

            if (w_done) begin
                r_lag_diff <= r_peak_lag;
                r_peak_out <= r_peak_run;
            end
        end
    end

    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.complete   = r_complete;
    assign bus.result     = r_result;
    assign bus.result_lag = r_result_lag;
    assign bus.lag_diff   = r_lag_diff;
    assign bus.peak_value = r_peak_out;
endmodule

// File: tb/tb_xcorr_lag_engine.sv
// Directed bench for xcorr_lag_engine: small instance (N=64, MAX_LAG=7) plus a default instance.
module tb_xcorr_lag_engine;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xcorr_lag_engine_if #(.W(16), .ACC_W(48), .LAG_W(6)) bus ();
    xcorr_lag_engine_if #(.W(16), .ACC_W(48), .LAG_W(6)) bus_f ();

    xcorr_lag_engine #(.W(16), .N(64), .MAX_LAG(7), .ACC_W(48), .LAG_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    xcorr_lag_engine #(.W(16), .N(512), .MAX_LAG(31), .ACC_W(48), .LAG_W(6)) dut_full (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f)
    );

    int total = 0;
    int bad   = 0;
    int gx[64];
    int gy[64];
    longint res_v[15];
    int res_l[15];
    int n_cmp;
    int lat;
    bit got_done;
    logic signed [5:0] exp_lag;
    longint exp_val;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frame();
        for (int n = 0; n < 64; n++) begin
            gx[n] = 0;
            gy[n] = 0;
        end
    endtask

    function automatic longint ref_r(input int k);
        longint s = 0;
        for (int n = 0; n < 64; n++) begin
            if (n + k >= 0 && n + k < 64) s += longint'(gx[n]) * longint'(gy[n + k]);
        end
        return s;
    endfunction

    // Start pulse (optionally with a junk sample on it), then the 64 frame samples.
    task automatic load_frame(input bit gaps, input bit junk);
        bus.start    = 1'b1;
        bus.in_valid = junk;
        bus.series_x = 16'sd12345;
        bus.series_y = -16'sd12345;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    bus.in_valid = 1'b0;
                    bus.series_x = 16'sd777;
                    bus.series_y = 16'sd777;
                    tick();
                end
            end
            bus.in_valid = 1'b1;
            bus.series_x = 16'(gx[n]);
            bus.series_y = 16'(gy[n]);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    // lat counts cycles from the last captured sample to the cycle done is seen.
    task automatic collect(input int budget);
        n_cmp    = 0;
        lat      = 1;
        got_done = 1'b0;
        while (!got_done && lat < budget) begin
            if (bus.complete) begin
                if (n_cmp < 15) begin
                    res_v[n_cmp] = bus.result;
                    res_l[n_cmp] = bus.result_lag;
                end
                n_cmp++;
            end
            if (bus.done) begin
                got_done = 1'b1;
            end else begin
                tick();
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        total++;
        if (bus.result !== 48'sd0 || bus.result_lag !== 6'sd0) begin
            bad++; $display("FAIL reset_result: got %0d/%0d want 0/0", bus.result, bus.result_lag);
        end
        total++;
        if (bus.lag_diff !== 6'sd0 || bus.peak_value !== 48'sd0 || bus.done !== 1'b0 ||
            bus.complete !== 1'b0) begin
            bad++; $display("FAIL reset_peak: got lag %0d peak %0d done %0b cmp %0b want 0",
                            bus.lag_diff, bus.peak_value, bus.done, bus.complete);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %0b want 0", bus.busy); end
    endtask

    task automatic test_delay();
        clear_frame();
        gx[10] = 1000;
        gy[13] = 1000;
        load_frame(1'b0, 1'b0);
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL delay_busy: got %0b want 1", bus.busy); end
        collect(1200);
        total++;
        if (!got_done || lat != 991) begin
            bad++; $display("FAIL delay_latency: got done=%0b lat=%0d want 1/991", got_done, lat);
        end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL delay_busy_done: got %0b want 0", bus.busy); end
        total++;
        if (n_cmp != 15) begin bad++; $display("FAIL delay_count: got %0d want 15", n_cmp); end
        for (int i = 0; i < 15; i++) begin
            exp_val = (i == 10) ? 64'sd1000000 : 64'sd0;
            total++;
            if (res_l[i] != i - 7 || res_v[i] != exp_val) begin
                bad++; $display("FAIL delay_r[%0d]: got lag %0d r %0d want lag %0d r %0d",
                                i, res_l[i], res_v[i], i - 7, exp_val);
            end
        end
        tick();
        exp_lag = 6'sd3;
        total++;
        if (bus.lag_diff !== exp_lag || bus.peak_value !== 48'sd1000000) begin
            bad++; $display("FAIL delay_peak: got %0d/%0d want 3/1000000", bus.lag_diff, bus.peak_value);
        end
    endtask

    task automatic test_reset_mid_calc();
        int seen;
        clear_frame();
        gx[10] = 1000;
        gy[3]  = 1000;
        load_frame(1'b0, 1'b0);
        for (int i = 0; i < 100; i++) tick();
        exp_lag = -6'sd7;
        total++;
        if (bus.result !== 48'sd1000000 || bus.result_lag !== exp_lag) begin
            bad++; $display("FAIL midcalc_result: got %0d/%0d want 1000000/-7", bus.result, bus.result_lag);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.result !== 48'sd0 || bus.result_lag !== 6'sd0) begin
            bad++; $display("FAIL async_reset_result: got busy %0b r %0d lag %0d want 0",
                            bus.busy, bus.result, bus.result_lag);
        end
        total++;
        if (bus.lag_diff !== 6'sd0 || bus.peak_value !== 48'sd0) begin
            bad++; $display("FAIL async_reset_peak: got %0d/%0d want 0/0", bus.lag_diff, bus.peak_value);
        end
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (bus.complete || bus.done || bus.busy) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL post_reset_quiet: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_ties();
        clear_frame();
        load_frame(1'b0, 1'b0);
        collect(1200);
        tick();
        exp_lag = -6'sd7;
        total++;
        if (!got_done || bus.lag_diff !== exp_lag || bus.peak_value !== 48'sd0) begin
            bad++; $display("FAIL zero_peak: got done %0b %0d/%0d want -7/0", got_done, bus.lag_diff,
                            bus.peak_value);
        end
        clear_frame();
        gx[5] = 100;
        gy[5] = -100;
        load_frame(1'b0, 1'b0);
        collect(1200);
        total++;
        if (n_cmp != 15 || res_v[7] != -64'sd10000 || res_v[6] != 64'sd0 || res_v[8] != 64'sd0) begin
            bad++; $display("FAIL neg_r0: got n %0d r0 %0d want 15/-10000", n_cmp, res_v[7]);
        end
        tick();
        total++;
        if (bus.lag_diff !== exp_lag || bus.peak_value !== 48'sd0) begin
            bad++; $display("FAIL neg_peak: got %0d/%0d want -7/0", bus.lag_diff, bus.peak_value);
        end
    endtask

    task automatic test_full_scale();
        longint r0, r31, full;
        int ncomp;
        bit fdone;
        r0 = 0;
        r31 = 0;
        ncomp = 0;
        fdone = 1'b0;
        full = longint'(1) << 39;
        bus_f.start = 1'b1;
        tick();
        bus_f.start = 1'b0;
        for (int n = 0; n < 512; n++) begin
            bus_f.in_valid = 1'b1;
            bus_f.series_x = 16'sh8000;
            bus_f.series_y = 16'sh8000;
            tick();
        end
        bus_f.in_valid = 1'b0;
        lat = 1;
        while (!fdone && lat < 33500) begin
            if (bus_f.complete) begin
                ncomp++;
                if (bus_f.result_lag == 6'sd0) r0 = bus_f.result;
                if (bus_f.result_lag == 6'sd31) r31 = bus_f.result;
            end
            if (bus_f.done) fdone = 1'b1;
            else begin tick(); lat++; end
        end
        total++;
        if (!fdone || lat != 32383 || ncomp != 63) begin
            bad++; $display("FAIL full_timing: got done %0b lat %0d n %0d want 1/32383/63", fdone, lat, ncomp);
        end
        total++;
        if (r0 != full) begin bad++; $display("FAIL full_r0: got %0d want %0d", r0, full); end
        total++;
        if (r31 != longint'(481) * (longint'(1) << 30)) begin
            bad++; $display("FAIL full_r31: got %0d want %0d", r31, longint'(481) * (longint'(1) << 30));
        end
        tick();
        total++;
        if (bus_f.lag_diff !== 6'sd0 || longint'(bus_f.peak_value) != full) begin
            bad++; $display("FAIL full_peak: got %0d/%0d want 0/%0d", bus_f.lag_diff, bus_f.peak_value, full);
        end
    endtask

    task automatic test_abort();
        int dones;
        clear_frame();
        gx[20] = 500;
        gy[24] = 300;
        load_frame(1'b0, 1'b0);
        collect(1200);
        tick();
        exp_lag = 6'sd4;
        total++;
        if (bus.lag_diff !== exp_lag || bus.peak_value !== 48'sd150000) begin
            bad++; $display("FAIL abort_prev: got %0d/%0d want 4/150000", bus.lag_diff, bus.peak_value);
        end
        clear_frame();
        gx[1] = 5;
        gy[1] = 5;
        load_frame(1'b0, 1'b0);
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.done) dones++;
        end
        clear_frame();
        gx[30] = 700;
        gy[25] = 200;
        load_frame(1'b0, 1'b0);
        collect(1200);
        total++;
        if (dones != 0 || !got_done || lat != 991) begin
            bad++; $display("FAIL abort_done: got early %0d done %0b lat %0d want 0/1/991", dones, got_done, lat);
        end
        total++;
        if (bus.lag_diff !== exp_lag) begin
            bad++; $display("FAIL abort_hold: got %0d want 4", bus.lag_diff);
        end
        tick();
        exp_lag = -6'sd5;
        total++;
        if (bus.lag_diff !== exp_lag || bus.peak_value !== 48'sd140000) begin
            bad++; $display("FAIL abort_new: got %0d/%0d want -5/140000", bus.lag_diff, bus.peak_value);
        end
    endtask

    task automatic test_handshake();
        longint best;
        int best_k;
        for (int n = 0; n < 64; n++) gx[n] = ((n * 37) % 200) - 100;
        for (int n = 0; n < 64; n++) gy[n] = (n >= 2) ? gx[n - 2] : 0;
        load_frame(1'b1, 1'b1);
        collect(1200);
        total++;
        if (!got_done || n_cmp != 15) begin
            bad++; $display("FAIL hs_done: got done %0b n %0d want 1/15", got_done, n_cmp);
        end
        best = ref_r(-7);
        best_k = -7;
        for (int i = 0; i < 15; i++) begin
            total++;
            if (res_l[i] != i - 7 || res_v[i] != ref_r(i - 7)) begin
                bad++; $display("FAIL hs_r[%0d]: got lag %0d r %0d want lag %0d r %0d",
                                i, res_l[i], res_v[i], i - 7, ref_r(i - 7));
            end
            if (ref_r(i - 7) > best) begin
                best = ref_r(i - 7);
                best_k = i - 7;
            end
        end
        tick();
        total++;
        if (int'(bus.lag_diff) != best_k || longint'(bus.peak_value) != best) begin
            bad++; $display("FAIL hs_peak: got %0d/%0d want %0d/%0d", bus.lag_diff, bus.peak_value,
                            best_k, best);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.series_x   = '0;
        bus.series_y   = '0;
        bus_f.start    = 1'b0;
        bus_f.in_valid = 1'b0;
        bus_f.series_x = '0;
        bus_f.series_y = '0;
        test_reset();
        test_delay();
        test_reset_mid_calc();
        test_ties();
        test_full_scale();
        test_abort();
        test_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
